// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : reg_scoreboard
// Brief    : Pending-write scoreboard for the 32 x 32-bit register file;
//            gates issue on RAW/saturation and retires counts on writeback.
// Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int CNT_W       = 3,
    parameter int MAX_PENDING = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic [ADDR_W-1:0]   issue_rs1,
    input  logic [ADDR_W-1:0]   issue_rs2,
    input  logic                issue_use_rs1,
    input  logic                issue_use_rs2,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic                issue_rd_we,
    input  logic                wb_valid,
    input  logic [ADDR_W-1:0]   wb_rd,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [7:0]          outstanding,
    output logic                err_underflow
);

    localparam logic [CNT_W-1:0] c_max  = CNT_W'(MAX_PENDING);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
    localparam logic [7:0]       c_one8 = 8'd1;

    logic [CNT_W-1:0]    r_count [NUM_REGS];
    logic [7:0]          r_outstanding;
    logic                r_err_underflow;

    logic                w_rs1_nz, w_rs2_nz, w_rd_nz, w_wb_nz;
    logic                w_hazard, w_sat, w_fire, w_inc, w_dec, w_underflow;
    logic [NUM_REGS-1:0] w_inc_vec, w_dec_vec;

    assign w_rs1_nz = (issue_rs1 != '0);
    assign w_rs2_nz = (issue_rs2 != '0);
    assign w_rd_nz  = (issue_rd  != '0);
    assign w_wb_nz  = (wb_rd     != '0);

    // Register 0 is never counted, so it can never produce a hazard.
    assign w_hazard = (issue_use_rs1 && w_rs1_nz && (r_count[issue_rs1] != '0)) ||
                      (issue_use_rs2 && w_rs2_nz && (r_count[issue_rs2] != '0));
    assign w_sat    = issue_rd_we && w_rd_nz && (r_count[issue_rd] == c_max);

    assign issue_ready = !w_hazard && !w_sat && !flush;
    assign w_fire      = issue_valid && issue_ready;
    assign w_inc       = w_fire && issue_rd_we && w_rd_nz;
    assign w_dec       = wb_valid && w_wb_nz && (r_count[wb_rd] != '0);
    assign w_underflow = wb_valid && w_wb_nz && (r_count[wb_rd] == '0);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign w_inc_vec[gi] = w_inc && (issue_rd == ADDR_W'(gi));
            assign w_dec_vec[gi] = w_dec && (wb_rd == ADDR_W'(gi));
            assign busy_vec[gi]  = (r_count[gi] != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_count[i] <= '0;
            end
            r_outstanding   <= '0;
            r_err_underflow <= 1'b0;
        end else if (flush) begin
            // Flush discards tracking but keeps the sticky error.
            for (int i = 0; i < NUM_REGS; i++) begin
                r_count[i] <= '0;
            end
            r_outstanding <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_inc_vec[i] && !w_dec_vec[i]) begin
                    r_count[i] <= r_count[i] + c_one;
                end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
                    r_count[i] <= r_count[i] - c_one;
                end
            end
            if (w_inc && !w_dec) begin
                r_outstanding <= r_outstanding + c_one8;
            end else if (w_dec && !w_inc) begin
                r_outstanding <= r_outstanding - c_one8;
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    assign outstanding   = r_outstanding;
    assign err_underflow = r_err_underflow;

endmodule
`default_nettype wire

// File: tb/tb_reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_scoreboard
// Brief    : Directed-vector scoreboard bench for reg_scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0, issue_ready;
    logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0, wb_rd = '0;
    logic        issue_use_rs1 = 1'b0, issue_use_rs2 = 1'b0, issue_rd_we = 1'b0;
    logic        wb_valid = 1'b0, flush = 1'b0;
    logic [31:0] busy_vec;
    logic [7:0]  outstanding;
    logic        err_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        rdy;
        logic [31:0] busy;
        logic [7:0]  outs;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_vec(busy_vec), .outstanding(outstanding),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, exp);
        end
    endfunction

    // Monitor: outputs are stable mid-cycle; compare against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "issue_ready",   {31'd0, issue_ready},   {31'd0, e.rdy});
            chk(e.name, "busy_vec",      busy_vec,               e.busy);
            chk(e.name, "outstanding",   {24'd0, outstanding},   {24'd0, e.outs});
            chk(e.name, "err_underflow", {31'd0, err_underflow}, {31'd0, e.err});
        end
    end

    // One cycle: drive inputs after the edge, queue what the outputs must show this cycle.
    task automatic step(input string nm,
                        input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we,
                        input logic wbv, input logic [4:0] wbr,
                        input logic fl, input logic r,
                        input logic e_rdy, input logic [31:0] e_busy,
                        input logic [7:0] e_outs, input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        issue_valid = v; issue_rs1 = rs1; issue_use_rs1 = u1;
        issue_rs2 = rs2; issue_use_rs2 = u2;
        issue_rd = rd;   issue_rd_we = we;
        wb_valid = wbv;  wb_rd = wbr;
        flush = fl;      rst = r;
        e.name = nm; e.rdy = e_rdy; e.busy = e_busy; e.outs = e_outs; e.err = e_err;
        exp_q.push_back(e);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        //     name          v  rs1 u1 rs2 u2 rd  we wbv wbr fl rst  rdy busy         outs err
        // RAW on rd=5, cleared one cycle after writeback
        step("reset_issue5", 1, 0,  0, 0,  0, 5,  1, 0,  0,  0, 0,   1, 32'h0,       0,  0);
        step("raw_rs1",      1, 5,  1, 0,  0, 0,  0, 0,  0,  0, 0,   0, 32'h20,      1,  0);
        step("raw_rs2",      1, 0,  0, 5,  1, 0,  0, 0,  0,  0, 0,   0, 32'h20,      1,  0);
        step("rs1_unused",   0, 5,  0, 0,  0, 0,  0, 0,  0,  0, 0,   1, 32'h20,      1,  0);
        step("wb5_nobypass", 1, 5,  1, 0,  0, 0,  0, 1,  5,  0, 0,   0, 32'h20,      1,  0);
        step("raw_cleared",  1, 5,  1, 0,  0, 0,  0, 0,  0,  0, 0,   1, 32'h0,       0,  0);
        // Register 0 is never tracked
        step("r0_traffic",   1, 0,  1, 0,  0, 0,  1, 1,  0,  0, 0,   1, 32'h0,       0,  0);
        step("r0_after",     0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 0,   1, 32'h0,       0,  0);
        // WAW to rd=7 up to saturation
        step("waw7_1",       1, 0,  0, 0,  0, 7,  1, 0,  0,  0, 0,   1, 32'h0,       0,  0);
        step("waw7_2",       1, 0,  0, 0,  0, 7,  1, 0,  0,  0, 0,   1, 32'h80,      1,  0);
        step("waw7_3",       1, 0,  0, 0,  0, 7,  1, 0,  0,  0, 0,   1, 32'h80,      2,  0);
        step("waw7_4",       1, 0,  0, 0,  0, 7,  1, 0,  0,  0, 0,   1, 32'h80,      3,  0);
        step("waw7_5",       1, 0,  0, 0,  0, 7,  1, 0,  0,  0, 0,   1, 32'h80,      4,  0);
        step("sat7",         1, 0,  0, 0,  0, 7,  1, 0,  0,  0, 0,   0, 32'h80,      5,  0);
        step("wb7_to4",      0, 0,  0, 0,  0, 0,  0, 1,  7,  0, 0,   1, 32'h80,      5,  0);
        step("issue_wb7",    1, 0,  0, 0,  0, 7,  1, 1,  7,  0, 0,   1, 32'h80,      4,  0);
        step("still4",       1, 0,  0, 0,  0, 7,  1, 0,  0,  0, 0,   1, 32'h80,      4,  0);
        step("sat7_again",   1, 0,  0, 0,  0, 7,  1, 0,  0,  0, 0,   0, 32'h80,      5,  0);
        step("flush7",       0, 0,  0, 0,  0, 0,  0, 0,  0,  1, 0,   0, 32'h80,      5,  0);
        step("flushed7",     0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 0,   1, 32'h0,       0,  0);
        // Sticky underflow survives traffic and flush
        step("wb9_underflow",0, 0,  0, 0,  0, 0,  0, 1,  9,  0, 0,   1, 32'h0,       0,  0);
        step("err_set",      1, 0,  0, 0,  0, 9,  1, 0,  0,  0, 0,   1, 32'h0,       0,  1);
        step("err_flush",    0, 0,  0, 0,  0, 0,  0, 0,  0,  1, 0,   0, 32'h200,     1,  1);
        step("err_kept",     0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 0,   1, 32'h0,       0,  1);
        // Flush discards both the pending state and a same-cycle issue
        step("iss3",         1, 0,  0, 0,  0, 3,  1, 0,  0,  0, 0,   1, 32'h0,       0,  1);
        step("iss4",         1, 0,  0, 0,  0, 4,  1, 0,  0,  0, 0,   1, 32'h8,       1,  1);
        step("iss3b",        1, 0,  0, 0,  0, 3,  1, 0,  0,  0, 0,   1, 32'h18,      2,  1);
        step("flush_iss8",   1, 0,  0, 0,  0, 8,  1, 0,  0,  1, 0,   0, 32'h18,      3,  1);
        step("after_flush",  0, 8,  1, 0,  0, 0,  0, 0,  0,  0, 0,   1, 32'h0,       0,  1);
        // Source read of own destination is not a hazard
        step("self_rs1_12",  1, 12, 1, 0,  0, 12, 1, 0,  0,  0, 0,   1, 32'h0,       0,  1);
        step("dep12",        0, 12, 1, 0,  0, 0,  0, 0,  0,  0, 0,   0, 32'h1000,    1,  1);
        // Reset dominates a same-cycle issue and writeback
        step("rst_dominant", 1, 0,  0, 0,  0, 20, 1, 1,  12, 0, 1,   1, 32'h1000,    1,  1);
        step("post_reset",   0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 0,   1, 32'h0,       0,  0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
